// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core vs. loader/debug port, with loader starvation
// override, exclusive loader lock, registered memory command and read-data routing.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic {NORMAL, LOCKED} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_starve;
    logic [CNT_W-1:0]  w_starve_nxt;
    logic              w_locked;
    logic              w_c_gnt;
    logic              w_l_gnt;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rd_c1;
    logic              r_rd_l1;
    logic              r_rd_c2;
    logic              r_rd_l2;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_l_rdata;

    // Lock only holds while l_lock stays high; the release cycle arbitrates as NORMAL.
    always_comb begin
        w_c_gnt      = 1'b0;
        w_l_gnt      = 1'b0;
        w_locked     = (r_state == LOCKED) && l_lock;
        w_starve_nxt = '0;
        w_state_nxt  = NORMAL;
        if (!Reset) begin
            if (w_locked) begin
                w_l_gnt = l_req;
            end else if (l_req && (!c_req || r_starve == STARVE_LIM)) begin
                w_l_gnt = 1'b1;
            end else begin
                w_c_gnt = c_req;
            end
        end
        if (l_req && !w_l_gnt) begin
            w_starve_nxt = (r_starve == STARVE_LIM) ? r_starve : r_starve + 1'b1;
        end
        if (l_lock && (w_locked || w_l_gnt)) begin
            w_state_nxt = LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= NORMAL;
            r_starve    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_c1     <= 1'b0;
            r_rd_l1     <= 1'b0;
            r_rd_c2     <= 1'b0;
            r_rd_l2     <= 1'b0;
            r_c_rdata   <= '0;
            r_l_rdata   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            r_mem_en <= w_c_gnt | w_l_gnt;
            if (w_l_gnt) begin
                r_mem_we    <= l_we;
                r_mem_addr  <= l_addr;
                r_mem_wdata <= l_wdata;
            end else if (w_c_gnt) begin
                r_mem_we    <= c_we;
                r_mem_addr  <= c_addr;
                r_mem_wdata <= c_wdata;
            end
            // Owner tracked through the command stage and the data-return stage.
            r_rd_c1 <= w_c_gnt & ~c_we;
            r_rd_l1 <= w_l_gnt & ~l_we;
            r_rd_c2 <= r_rd_c1;
            r_rd_l2 <= r_rd_l1;
            if (r_rd_c2) r_c_rdata <= mem_rdata;
            if (r_rd_l2) r_l_rdata <= mem_rdata;
        end
    end

    assign c_gnt     = w_c_gnt;
    assign l_gnt     = w_l_gnt;
    assign c_stall   = c_req & ~w_c_gnt;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign c_rvalid  = r_rd_c2;
    assign l_rvalid  = r_rd_l2;
    assign c_rdata   = r_rd_c2 ? mem_rdata : r_c_rdata;
    assign l_rdata   = r_rd_l2 ? mem_rdata : r_l_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: reference arbitration model predicts grants,
// memory commands and read returns; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0;
    logic        c_gnt, c_stall, c_rvalid, l_gnt, l_rvalid;
    logic [31:0] c_rdata, l_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .Reset(Reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } mem_t;

    typedef struct {
        int unsigned due;
        logic        own_l;
        logic [31:0] data;
    } rd_t;

    mem_t        mem_q[$];
    rd_t         rd_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 0;
    logic        last_we = 1'b0;
    logic [31:0] last_addr = '0, last_wd = '0, hold_c = '0, hold_l = '0;
    bit          m_locked = 0;
    int          m_starve = 0;

    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (mem_en && !mem_we) mem_rdata <= data_for(mem_addr);
        else                   mem_rdata <= $urandom();
    end

    // Monitor: compares registered outputs against the scoreboard.
    initial forever begin
        mem_t me;
        rd_t  re;
        @(negedge clk);
        if (mon_en) begin
            if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
                me = mem_q.pop_front();
                chk("mem_en", mem_en, 1);
                chk("mem_we", mem_we, me.we);
                chk("mem_addr", mem_addr, me.addr);
                chk("mem_wdata", mem_wdata, me.wd);
                last_we = me.we; last_addr = me.addr; last_wd = me.wd;
            end else begin
                chk("mem_en_idle", mem_en, 0);
                chk("mem_we_hold", mem_we, last_we);
                chk("mem_addr_hold", mem_addr, last_addr);
                chk("mem_wdata_hold", mem_wdata, last_wd);
            end
            if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                re = rd_q.pop_front();
                chk("c_rvalid", c_rvalid, !re.own_l);
                chk("l_rvalid", l_rvalid, re.own_l);
                if (re.own_l) begin
                    chk("l_rdata", l_rdata, re.data);
                    chk("c_rdata_hold", c_rdata, hold_c);
                    hold_l = re.data;
                end else begin
                    chk("c_rdata", c_rdata, re.data);
                    chk("l_rdata_hold", l_rdata, hold_l);
                    hold_c = re.data;
                end
            end else begin
                chk("c_rvalid_idle", c_rvalid, 0);
                chk("l_rvalid_idle", l_rvalid, 0);
                chk("c_rdata_hold", c_rdata, hold_c);
                chk("l_rdata_hold", l_rdata, hold_l);
            end
        end
    end

    task automatic step(input logic rst, input logic creq, input logic cwe,
                        input logic [31:0] caddr, input logic [31:0] cwd,
                        input logic lreq, input logic lwe,
                        input logic [31:0] laddr, input logic [31:0] lwd,
                        input logic llock, output logic og_c, output logic og_l);
        logic eg_c, eg_l;
        @(negedge clk);
        #1;
        Reset = rst; c_req = creq; c_we = cwe; c_addr = caddr; c_wdata = cwd;
        l_req = lreq; l_we = lwe; l_addr = laddr; l_wdata = lwd; l_lock = llock;
        #1;
        eg_c = 1'b0; eg_l = 1'b0;
        if (!rst) begin
            if (m_locked && llock)                    eg_l = lreq;
            else if (lreq && (!creq || m_starve >= SM)) eg_l = 1'b1;
            else                                      eg_c = creq;
        end
        chk("c_gnt", c_gnt, eg_c);
        chk("l_gnt", l_gnt, eg_l);
        chk("c_stall", c_stall, creq & ~eg_c);
        if (rst) begin
            while (mem_q.size() != 0 && mem_q[$].due > cyc) void'(mem_q.pop_back());
            while (rd_q.size() != 0 && rd_q[$].due > cyc) void'(rd_q.pop_back());
            last_we = 1'b0; last_addr = '0; last_wd = '0; hold_c = '0; hold_l = '0;
            m_locked = 0; m_starve = 0;
        end else begin
            if (eg_c) begin
                mem_q.push_back('{cyc + 1, cwe, caddr, cwd});
                if (!cwe) rd_q.push_back('{cyc + 2, 1'b0, data_for(caddr)});
            end
            if (eg_l) begin
                mem_q.push_back('{cyc + 1, lwe, laddr, lwd});
                if (!lwe) rd_q.push_back('{cyc + 2, 1'b1, data_for(laddr)});
            end
            m_starve = (lreq && !eg_l) ? ((m_starve >= SM) ? SM : m_starve + 1) : 0;
            m_locked = llock && (m_locked || eg_l);
        end
        og_c = c_gnt;
        og_l = l_gnt;
    endtask

    task automatic idle(input int n);
        logic gc, gl;
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, gc, gl);
    endtask

    initial begin
        logic       gc, gl;
        logic [9:0] cpat, lpat;

        // reset: grants low while Reset high; registered state checked by the monitor
        step(1, 1, 0, 32'h44, '0, 1, 0, 32'h48, '0, 1, gc, gl);
        mon_en = 1;
        step(1, 1, 1, 32'h44, 32'h1, 0, 0, '0, '0, 0, gc, gl);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_c_rdata", c_rdata, 0);

        // single core read
        step(0, 1, 0, 32'h10, '0, 0, 0, '0, '0, 0, gc, gl);
        idle(3);

        // continuous contention: loader forced through every fifth cycle
        cpat = '0; lpat = '0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, i[0], 32'h100 + i, 32'hC000 + i, 1, 0, 32'h200 + i, '0, 0, gc, gl);
            cpat = {cpat[8:0], gc};
            lpat = {lpat[8:0], gl};
        end
        chk("starve_l_pattern", lpat, 10'b0000100001);
        chk("starve_c_pattern", cpat, 10'b1111011110);
        idle(3);

        // lock: core shut out while l_lock held, core wins on release cycle
        cpat = '0;
        step(0, 0, 0, '0, '0, 1, 1, 32'h300, 32'hA1, 1, gc, gl);
        cpat = {cpat[8:0], gc};
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h50 + i, '0, 1, i[0], 32'h310 + i, 32'hB0 + i, 1, gc, gl);
            cpat = {cpat[8:0], gc};
        end
        step(0, 1, 0, 32'h60, '0, 1, 0, 32'h320, '0, 0, gc, gl);
        cpat = {cpat[8:0], gc};
        chk("lock_c_pattern", cpat[4:0], 5'b00001);
        idle(3);

        // back-to-back loader read then core write
        step(0, 0, 0, '0, '0, 1, 0, 32'h20, '0, 0, gc, gl);
        step(0, 1, 1, 32'h24, 32'h5555AAAA, 0, 0, '0, '0, 0, gc, gl);
        idle(3);

        // l_lock without l_req, then lock request while core wins
        step(0, 1, 0, 32'h70, '0, 0, 0, '0, '0, 1, gc, gl);
        step(0, 1, 0, 32'h74, '0, 0, 0, '0, '0, 1, gc, gl);
        chk("nolock_core_wins", gc, 1);
        for (int i = 0; i < 7; i++)
            step(0, 1, 0, 32'h80 + i, '0, 1, 0, 32'h400 + i, '0, 1, gc, gl);
        step(0, 1, 0, 32'h90, '0, 0, 0, '0, '0, 0, gc, gl);
        idle(2);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 255)), $urandom(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 255)), $urandom(),
                 1'($urandom_range(0, 3) == 0), gc, gl);
        end
        idle(3);

        // reset with a read in flight; starvation count restarts
        step(0, 1, 0, 32'h34, '0, 0, 0, '0, '0, 0, gc, gl);
        step(1, 1, 0, 32'h38, '0, 1, 0, 32'h3C, '0, 0, gc, gl);
        idle(3);
        lpat = '0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 32'h500 + i, 32'h77 + i, 1, 1, 32'h600 + i, 32'h99 + i, 0, gc, gl);
            lpat = {lpat[8:0], gl};
        end
        chk("post_reset_l_pattern", lpat[4:0], 5'b00001);
        idle(4);

        chk("sb_mem_drained", mem_q.size(), 0);
        chk("sb_rd_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
